// File: rtl/coco_intc.sv
// Interrupt collector: edge-captured pending bits, per-source mask, lowest-index
// priority and a single in-service slot with vector readout and EOI.
module coco_intc #(
  parameter int N_SRC = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:2]       ADD_I,
  input  logic             WE_I,
  input  logic [31:0]      DAT_I,
  output logic [31:0]      DAT_O,
  input  logic [N_SRC-1:0] IRQ_I,
  input  logic             INT_ACK_I,
  output logic             IRQ_O
);

  localparam logic [1:0] A_CTRL = 2'b00;
  localparam logic [1:0] A_MASK = 2'b01;
  localparam logic [1:0] A_PEND = 2'b10;
  localparam logic [1:0] A_VEC  = 2'b11;

  localparam logic [0:0] S_IDLE    = 1'b0;
  localparam logic [0:0] S_SERVICE = 1'b1;

  logic [N_SRC-1:0] pend_q, pend_d;
  logic [N_SRC-1:0] mask_q, mask_d;
  logic [N_SRC-1:0] prev_q;
  logic             ge_q, ge_d;
  logic [0:0]       is_q, is_d;
  logic [2:0]       id_q, id_d;

  logic [N_SRC-1:0] req, rise, win_oh;
  logic [2:0]       win;
  logic             ack;

  assign req   = pend_q & mask_q;
  assign rise  = IRQ_I & ~prev_q;
  assign IRQ_O = ge_q & (is_q == S_IDLE) & (|req);
  assign ack   = INT_ACK_I & IRQ_O;

  // Scan from the top so the lowest requesting index is the last to assign.
  always_comb begin
    win    = 3'd0;
    win_oh = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (req[i]) begin
        win    = 3'(i);
        win_oh = N_SRC'(1) << i;
      end
    end
  end

  always_comb begin
    pend_d = pend_q;
    mask_d = mask_q;
    ge_d   = ge_q;
    is_d   = is_q;
    id_d   = id_q;
    if (WE_I) begin
      case (ADD_I)
        A_CTRL:  ge_d = DAT_I[0];
        A_MASK:  mask_d = DAT_I[N_SRC-1:0];
        A_PEND:  pend_d = pend_d & ~DAT_I[N_SRC-1:0];
        A_VEC:   if (is_q == S_SERVICE) is_d = S_IDLE;
        default: ;
      endcase
    end
    if (ack) begin
      is_d   = S_SERVICE;
      id_d   = win;
      pend_d = pend_d & ~win_oh;
    end
    // New edges override any clear landing on the same edge.
    pend_d = pend_d | rise;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q <= '0;
      mask_q <= '0;
      prev_q <= '0;
      ge_q   <= 1'b0;
      is_q   <= S_IDLE;
      id_q   <= 3'd0;
    end else begin
      pend_q <= pend_d;
      mask_q <= mask_d;
      prev_q <= IRQ_I;
      ge_q   <= ge_d;
      is_q   <= is_d;
      id_q   <= id_d;
    end
  end

  always_comb begin
    DAT_O = 32'd0;
    case (ADD_I)
      A_CTRL:  DAT_O = {30'd0, is_q, ge_q};
      A_MASK:  DAT_O = {{(32-N_SRC){1'b0}}, mask_q};
      A_PEND:  DAT_O = {{(32-N_SRC){1'b0}}, pend_q};
      A_VEC:   DAT_O = {is_q, 28'd0, id_q};
      default: DAT_O = 32'd0;
    endcase
  end

endmodule
